sseg4_scan_ctrl: RTL and testbench
==================================

Name: sseg4_scan_ctrl

Overview:
Time-multiplexes one shared BCD-to-seven-segment decoder across a four-digit common-anode display. Sits between the value source (counter or user logic) and the decoder.
- Drives the decoder's 4-bit BCD input and the four active-low anode enables.
- Inserts blanking dead time between digits to suppress ghosting.
- Double-buffers the displayed value so a digit update never tears mid-frame.

Parameters:
DIGIT_CYCLES, 50000, clock cycles per digit slot, blank portion included; must be > BLANK_CYCLES.
BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; must be >= 1.
CNT_W, 16, slot-counter width; must hold DIGIT_CYCLES-1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
value  input  16  four BCD nibbles: [3:0] digit0 (rightmost) through [15:12] digit3.
load  input  1  one-cycle strobe; captures value into the pending buffer.
bcd_out  output  4  nibble to the shared decoder.
an  output  4  anode enables, active-low; an[i]=0 lights digit i.
digit_sel  output  2  index of the current slot.
frame_tick  output  1  one-cycle pulse on the last cycle of digit 3's slot.
bad_digit  output  1  sticky flag: a nibble >9 was loaded.

Behaviour:
- Reset (async assert, sync to clk on release): state=BLANK, digit_sel=0, slot counter=0, an=4'b1111, bcd_out=0, frame_tick=0, bad_digit=0, pending and active buffers=16'h0000.
- Slot counter: counts 0..DIGIT_CYCLES-1, then wraps to 0 and digit_sel increments mod 4 (3 wraps to 0).
- FSM, two states:
  - BLANK: an=4'b1111. When counter==BLANK_CYCLES-1, go to SHOW.
  - SHOW: an=~(4'b0001<<digit_sel). When counter==DIGIT_CYCLES-1, go to BLANK and advance digit_sel.
- bcd_out = active[4*digit_sel +: 4]. It is registered and updates on the same edge that changes digit_sel, i.e. during blank time, so the decoder has settled before the anode turns on.
- Latency:
  - An anode goes low exactly BLANK_CYCLES cycles after its slot starts.
  - Full frame = 4*DIGIT_CYCLES cycles.
- Load:
  - load=1 captures value into pending on that edge.
  - pending is copied to active only on the edge where digit_sel wraps 3->0, i.e. the same edge frame_tick is high.
  - If load and that frame-boundary edge coincide, the value being loaded goes straight into both pending and active. New data is never lost or delayed a frame.
  - Multiple loads within one frame: the last one wins.
- frame_tick: high for exactly one cycle, the cycle where digit_sel==3 and counter==DIGIT_CYCLES-1.
- bad_digit: set on any load whose value has any nibble >9. Cleared only by rst.
  - The nibble is still displayed.
  - The decoder outputs all segments on for it.
- Reset mid-frame: an goes to 4'b1111 immediately (asynchronous); the scan restarts at digit 0, BLANK.
- Outputs: all registered; no combinational path from inputs to outputs.

Optional Feature:
LEADING_ZERO_BLANK_EN.
- Defined:
  - During SHOW, digit i stays dark (an[i]=1) if active nibble i and every higher nibble are 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Slot timing and frame_tick are unchanged.
- Undefined: all four digits are always lit in SHOW.

Test Plan:
1. Reset scan, DIGIT_CYCLES=8, BLANK_CYCLES=2: release rst -> an=1111 for 2 cycles, then 1110 for 6 cycles; then 1111 for 2 and 1101 for 6; frame_tick pulses every 32 cycles.
2. load value=16'h1234 mid-frame -> bcd_out unchanged until the next frame_tick edge. Next frame: bcd_out=4,3,2,1 while an=1110,1101,1011,0111 respectively.
3. load on the exact frame_tick cycle with 16'h5678 -> the next frame already shows 8,7,6,5. Two loads in one frame (16'h1111 then 16'h2222) -> only 2222 is displayed.
4. load 16'h00A3 -> bad_digit=1 and stays 1 across later valid loads until rst.
5. Assert rst during SHOW of digit 2 -> an=1111 within the same cycle, without waiting for a clk edge. After release, the scan restarts at digit 0 with an=1111 for BLANK_CYCLES.
6. With LEADING_ZERO_BLANK_EN, load 16'h0042 -> digits 3 and 2 stay dark; digits 1 and 0 light. Load 16'h0000 -> only digit 0 lights, with bcd_out=0.

Source files
------------

// File: rtl/sseg4_scan_ctrl.sv
// sseg4_scan_ctrl: four-digit common-anode scan controller feeding one shared
// BCD-to-seven-segment decoder. Each digit slot opens with a blanking window
// (all anodes off) so the decoder settles before the anode turns on. The
// displayed value is double-buffered and only swaps at the frame boundary.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, leading-zero digits (3..1) stay dark during SHOW.
//   Digit 0 is never blanked. Slot timing and frame_tick are unchanged.
module sseg4_scan_ctrl #(
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  bcd_out,
  output logic [3:0]  an,
  output logic [1:0]  digit_sel,
  output logic        frame_tick,
  output logic        bad_digit
);

  localparam int unsigned VAL_W  = 16;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned N_DIG  = 4;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(N_DIG - 1);
  localparam logic [NIB_W-1:0] ANODES_OFF = '1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic [SEL_W-1:0]  dsel_nx;
  logic [VAL_W-1:0]  pending;
  logic [VAL_W-1:0]  pending_nx;
  logic [VAL_W-1:0]  active;
  logic [VAL_W-1:0]  active_nx;
  logic [NIB_W-1:0]  bcd_nx;
  logic [NIB_W-1:0]  an_nx;
  logic [NIB_W-1:0]  dark_c;
  logic              ft_nx;
  logic              bad_nx;
  logic              slot_end_c;
  logic              frame_end_c;

  // True if any BCD nibble of v lies outside 0..9.
  function automatic logic has_bad_nibble(input logic [VAL_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(N_DIG); i++) begin
      if (v[NIB_W*i +: NIB_W] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Selects nibble sel out of the 16-bit display word.
  function automatic logic [NIB_W-1:0] pick_nibble(input logic [VAL_W-1:0] v,
                                                   input logic [SEL_W-1:0] sel);
    logic [NIB_W-1:0] nib;
    case (sel)
      2'd0:    nib = v[3:0];
      2'd1:    nib = v[7:4];
      2'd2:    nib = v[11:8];
      default: nib = v[15:12];
    endcase
    return nib;
  endfunction

  // Per-digit dark mask: a digit is dark when it and every higher digit are 0.
  function automatic logic [NIB_W-1:0] lead_zero_mask(input logic [VAL_W-1:0] v);
    logic [NIB_W-1:0] m;
    m    = '0;
    m[3] = (v[15:12] == 4'd0);
    m[2] = m[3] && (v[11:8] == 4'd0);
    m[1] = m[2] && (v[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction

  // Next-state, slot timing, buffer update and next registered outputs.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt + CNT_W'(1);
    dsel_nx     = digit_sel;
    pending_nx  = pending;
    active_nx   = active;
    bad_nx      = bad_digit;
    an_nx       = ANODES_OFF;
    bcd_nx      = '0;
    ft_nx       = 1'b0;
    dark_c      = '0;
    slot_end_c  = (cnt == CNT_LAST);
    frame_end_c = slot_end_c && (digit_sel == SEL_LAST);

    if (slot_end_c) begin
      cnt_nx  = '0;
      dsel_nx = digit_sel + SEL_W'(1);
    end

    case (state)
      ST_BLANK: if (cnt == BLANK_LAST) state_nx = ST_SHOW;
      ST_SHOW:  if (slot_end_c)        state_nx = ST_BLANK;
      default:                         state_nx = ST_BLANK;
    endcase

    // Last load in a frame wins; a bad nibble latches the sticky flag.
    if (load) begin
      pending_nx = value;
      if (has_bad_nibble(value)) bad_nx = 1'b1;
    end

    // Swap buffers at the frame boundary; a coincident load goes straight in.
    if (frame_end_c) active_nx = pending_nx;

`ifdef LEADING_ZERO_BLANK_EN
    dark_c = lead_zero_mask(active_nx);
`else
    dark_c = '0;
`endif

    bcd_nx = pick_nibble(active_nx, dsel_nx);
    if (state_nx == ST_SHOW) begin
      an_nx = ~(NIB_W'(1) << dsel_nx) | dark_c;
    end
    ft_nx = (dsel_nx == SEL_LAST) && (cnt_nx == CNT_LAST);
  end

  // State, counters, buffers and all outputs; async reset blanks the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      digit_sel  <= '0;
      pending    <= '0;
      active     <= '0;
      bcd_out    <= '0;
      an         <= ANODES_OFF;
      frame_tick <= 1'b0;
      bad_digit  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      digit_sel  <= dsel_nx;
      pending    <= pending_nx;
      active     <= active_nx;
      bcd_out    <= bcd_nx;
      an         <= an_nx;
      frame_tick <= ft_nx;
      bad_digit  <= bad_nx;
    end
  end

endmodule

// File: tb/tb_sseg4_scan_ctrl.sv
// Testbench for sseg4_scan_ctrl: stimulus pushes per-cycle expectations from a
// cycle-index reference model into a queue; a monitor pops and compares them.
module tb_sseg4_scan_ctrl;

  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * DC;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic [1:0]  digit_sel;
  logic        frame_tick;
  logic        bad_digit;

  sseg4_scan_ctrl #(
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .load(load),
    .bcd_out(bcd_out),
    .an(an),
    .digit_sel(digit_sel),
    .frame_tick(frame_tick),
    .bad_digit(bad_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [3:0] an;
    logic [3:0] bcd;
    logic [1:0] ds;
    logic       ft;
    logic       bad;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          t;
  logic [15:0] pend_m;
  logic [15:0] act_m;
  logic        bad_m;

  task automatic check(input string name, input int tt, input logic [15:0] got,
                       input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0d got %h expected %h", name, tt, got, want);
    end
  endtask

  function automatic logic any_bad(input logic [15:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < 4; i++) if (((v >> (4 * i)) & 16'hF) > 16'd9) b = 1'b1;
    return b;
  endfunction

  // Expected outputs for cycle tt after reset release, from slot arithmetic.
  function automatic exp_t model(input int tt);
    exp_t e;
    int   off;
    int   slot;
    off   = tt % DC;
    slot  = (tt / DC) % 4;
    e.t   = tt;
    e.ds  = 2'(slot);
    e.bcd = 4'(act_m >> (4 * slot));
    e.ft  = (slot == 3) && (off == DC - 1);
    e.bad = bad_m;
    if (off < BC) begin
      e.an = 4'hF;
    end else begin
      e.an = ~(4'(1) << slot);
`ifdef LEADING_ZERO_BLANK_EN
      if (slot != 0 && (act_m >> (4 * slot)) == 16'h0) e.an = 4'hF;
`endif
    end
    return e;
  endfunction

  // Monitor: every cycle the DUT presents a new output set; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      check("an",         mon_e.t, 16'(an),         16'(mon_e.an));
      check("bcd_out",    mon_e.t, 16'(bcd_out),    16'(mon_e.bcd));
      check("digit_sel",  mon_e.t, 16'(digit_sel),  16'(mon_e.ds));
      check("frame_tick", mon_e.t, 16'(frame_tick), 16'(mon_e.ft));
      check("bad_digit",  mon_e.t, 16'(bad_digit),  16'(mon_e.bad));
    end
  end

  // One clock of stimulus: advance the model, queue its expectation, drive inputs.
  task automatic step(input bit ld, input logic [15:0] v);
    @(posedge clk);
    #1;
    t++;
    if (t % FRAME == 0) act_m = pend_m;
    q.push_back(model(t));
    load  = ld;
    value = v;
    if (ld) begin
      pend_m = v;
      if (any_bad(v)) bad_m = 1'b1;
    end
  endtask

  // Assert reset between clock edges and verify the outputs drop immediately.
  task automatic do_reset();
    @(negedge clk);
    #1;
    load = 1'b0;
    rst  = 1'b1;
    #1;
    check("rst_an",         -1, 16'(an),         16'hF);
    check("rst_bcd_out",    -1, 16'(bcd_out),    16'h0);
    check("rst_digit_sel",  -1, 16'(digit_sel),  16'h0);
    check("rst_frame_tick", -1, 16'(frame_tick), 16'h0);
    check("rst_bad_digit",  -1, 16'(bad_digit),  16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    t      = 0;
    pend_m = 16'h0;
    act_m  = 16'h0;
    bad_m  = 1'b0;
  endtask

  function automatic logic [15:0] rand_val(input bit allow_bad);
    logic [15:0] v;
    int          ndig;
    v    = 16'h0;
    ndig = $urandom_range(0, 4);
    for (int i = 0; i < ndig; i++) begin
      if (allow_bad && $urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else                                        v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  task automatic rand_run(input int n, input bit allow_bad);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 15) == 0) step(1'b1, rand_val(allow_bad));
      else                            step(1'b0, 16'($urandom));
    end
  endtask

  initial begin
    rst    = 1'b0;
    load   = 1'b0;
    value  = 16'h0;
    t      = 0;
    pend_m = 16'h0;
    act_m  = 16'h0;
    bad_m  = 1'b0;
    do_reset();

    // Scan from reset with a blank value: two full frames and change.
    repeat (70) step(1'b0, 16'h0);

    // Mid-frame load only shows from the next frame on.
    repeat (5) step(1'b0, 16'h0);
    step(1'b1, 16'h1234);
    repeat (2 * FRAME) step(1'b0, 16'hFFFF);

    // Load on the frame_tick cycle goes straight to the display.
    while (((t + 1) % FRAME) != FRAME - 1) step(1'b0, 16'h0);
    step(1'b1, 16'h5678);
    repeat (FRAME + 4) step(1'b0, 16'h0);

    // Two loads within one frame: the later one wins.
    while (((t + 1) % FRAME) != 3) step(1'b0, 16'h0);
    step(1'b1, 16'h1111);
    repeat (6) step(1'b0, 16'h0);
    step(1'b1, 16'h2222);
    repeat (2 * FRAME) step(1'b0, 16'h0);

    rand_run(1500, 1'b0);

    // Out-of-range nibble latches bad_digit; later valid loads do not clear it.
    step(1'b1, 16'h00A3);
    repeat (FRAME) step(1'b0, 16'h0);
    step(1'b1, 16'h0987);
    repeat (2 * FRAME) step(1'b0, 16'h0);

    // Reset during SHOW of digit 2.
    while (!(((t / DC) % 4) == 2 && (t % DC) == BC + 1)) step(1'b0, 16'h0);
    do_reset();
    repeat (FRAME) step(1'b0, 16'h0);

    // Leading-zero patterns.
    step(1'b1, 16'h0042);
    repeat (2 * FRAME) step(1'b0, 16'h0);
    step(1'b1, 16'h0000);
    repeat (2 * FRAME) step(1'b0, 16'h0);

    rand_run(1500, 1'b1);
    load = 1'b0;

    @(negedge clk);
    #1;
    check("queue_drained", t, 16'(q.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0d got timeout expected finish", t);
    $fatal(1, "watchdog expired");
  end

endmodule
